// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end for the MIPS core.
// Issues one word read at a time to instruction memory, buffers returned
// words with their addresses in a DEPTH-entry FIFO, and presents the head
// instruction to the controller/datapath. A consumed taken branch or jump
// flushes the FIFO and restarts fetch at the target.
//
// Optional build macro: FETCH_BYPASS_EN
//   defined   : an ack arriving while the FIFO is empty is presented
//               combinationally in the ack cycle (0-cycle ack-to-use).
//   undefined : all head outputs come from FIFO registers (1-cycle latency).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request outstanding; issue when the FIFO has room
// BUSY  | request outstanding; its data will be pushed on ack
// DRAIN | wrong-path request outstanding; its data is dropped on ack,
//       | then fetch restarts at the stored redirect target
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [31:0] pcbranch
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   next_pc_q, next_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic        fifo_empty;
    logic        bypass;
    logic        head_valid;
    logic [31:0] head_instr;
    logic [31:0] head_pc;
    logic        consume;
    logic        redirect;
    logic [31:0] jump_target;
    logic [31:0] target;
    logic        push;
    logic        pop;
    logic        issue_ok;
    logic        issue;
    logic [31:0] issue_addr;

    assign fifo_empty = (count_q == '0);

`ifdef FETCH_BYPASS_EN
    // Only a BUSY ack is live data; a DRAIN ack is wrong-path and never bypassed.
    assign bypass = fifo_empty & imem_ack & (state_q == S_BUSY);
`else
    assign bypass = 1'b0;
`endif

    // Head selection: FIFO entry, or the in-flight ack word when bypassing.
    always_comb begin
        head_valid = ~fifo_empty | bypass;
        head_instr = bypass ? imem_rdata : instr_mem[rd_ptr_q];
        head_pc    = bypass ? imem_addr  : pc_mem[rd_ptr_q];
        if (!head_valid) begin
            head_instr = 32'd0;
            head_pc    = 32'd0;
        end
    end

    assign instr_valid = head_valid;
    assign instr       = head_instr;
    assign pc          = head_pc;
    assign pcplus4     = head_pc + 32'd4;
    assign op          = head_instr[31:26];
    assign funct       = head_instr[5:0];
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;

    assign consume     = head_valid & instr_ready;
    assign redirect    = consume & (pcsrc | jump);
    assign jump_target = {pcplus4[31:28], head_instr[25:0], 2'b00};
    assign target      = jump ? jump_target : pcbranch;

    // A bypassed word that is consumed in its ack cycle never enters the FIFO.
    assign push = imem_ack & (state_q == S_BUSY) & ~redirect & ~(bypass & consume);
    assign pop  = consume & ~bypass;

    // FIFO occupancy and pointers after this cycle; a redirect empties it.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    // Any request completing this cycle is no longer outstanding, so room is
    // judged against the post-cycle occupancy alone.
    assign issue_ok = (count_d < DEPTH_C);

    // Request FSM: decide whether to issue, where, and the next state.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        next_pc_d  = next_pc_q;
        issue      = 1'b0;
        issue_addr = next_pc_q;
        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    issue      = 1'b1;
                    issue_addr = target;
                end else if (issue_ok) begin
                    issue = 1'b1;
                end
            end
            S_BUSY: begin
                if (imem_ack) begin
                    if (redirect) begin
                        issue      = 1'b1;
                        issue_addr = target;
                    end else if (issue_ok) begin
                        issue = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end
                end else if (redirect) begin
                    state_d   = S_DRAIN;
                    next_pc_d = target;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    issue      = 1'b1;
                    issue_addr = redirect ? target : next_pc_q;
                end else if (redirect) begin
                    next_pc_d = target;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
        if (issue) begin
            state_d   = S_BUSY;
            req_d     = 1'b1;
            addr_d    = issue_addr;
            next_pc_d = issue_addr + 32'd4;
        end
    end

    // Control registers; reset abandons any outstanding request immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            addr_q    <= RESET_PC;
            next_pc_q <= RESET_PC;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            next_pc_q <= next_pc_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    // FIFO storage; contents are only observed through valid entries.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= imem_addr;
            instr_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        pcsrc = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] pcbranch = 32'd0;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .pc         (pc),
        .pcplus4    (pcplus4),
        .op         (op),
        .funct      (funct),
        .pcsrc      (pcsrc),
        .jump       (jump),
        .pcbranch   (pcbranch)
    );

    int checks = 0;
    int errors = 0;

    // memory responder state
    logic        serving = 1'b0;
    logic [31:0] serving_addr = 32'd0;
    int          cnt = 0;
    int          mem_lat = 1;
    bit          lat_rand = 1'b0;
    int          acks = 0;
    logic [31:0] req_log [$];
    logic [31:0] ovr_addr [4];
    logic [31:0] ovr_word [4];
    int          ovr_n = 0;

    // program-order reference model
    logic [31:0] exp_pc = 32'd0;
    logic [31:0] cons_pcs [$];
    int          ncons = 0;

    typedef struct {
        logic [31:0] word;
        logic        pcsrc;
        logic        jump;
        logic [31:0] br;
        int          lat;
        logic [5:0]  exp_op;
        logic [5:0]  exp_funct;
        logic [31:0] exp_next;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %h want %h @%0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = (a * 32'h9E37_79B1) ^ 32'h1234_5678;
        for (int k = 0; k < ovr_n; k++)
            if (ovr_addr[k] == a) w = ovr_word[k];
        return w;
    endfunction

    task automatic mem_drive();
        imem_rdata = 32'hDEAD_BEEF;
        if (reset || !imem_req) begin
            imem_ack = 1'b0;
            serving  = 1'b0;
        end else if (!serving) begin
            serving      = 1'b1;
            serving_addr = imem_addr;
            req_log.push_back(imem_addr);
            cnt      = (lat_rand ? int'($urandom_range(1, 4)) : mem_lat) - 1;
            imem_ack = 1'b0;
        end else begin
            chk("addr_stable", imem_addr, serving_addr);
            if (cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                serving    = 1'b0;
                acks++;
            end else begin
                cnt--;
                imem_ack = 1'b0;
            end
        end
    endtask

    task automatic tick_a();
        @(negedge clk);
        mem_drive();
        #1;
    endtask

    task automatic commit();
        logic [31:0] w, p4;
        if (!instr_valid) begin
            chk("idle_instr", instr, 32'd0);
            chk("idle_pc", pc, 32'd0);
            chk("idle_opfunct", {20'd0, op, funct}, 32'd0);
            chk("idle_pcplus4", pcplus4, 32'd4);
        end else if (instr_ready) begin
            w  = mem_word(exp_pc);
            p4 = exp_pc + 32'd4;
            chk("cons_pc", pc, exp_pc);
            chk("cons_instr", instr, w);
            chk("cons_op", 32'(op), 32'(w[31:26]));
            chk("cons_funct", 32'(funct), 32'(w[5:0]));
            chk("cons_pcplus4", pcplus4, p4);
            cons_pcs.push_back(pc);
            ncons++;
            if (jump)       exp_pc = {p4[31:28], w[25:0], 2'b00};
            else if (pcsrc) exp_pc = pcbranch;
            else            exp_pc = p4;
        end
    endtask

    task automatic tick_b(input logic rdy, input logic pcs, input logic jmp, input logic [31:0] br);
        instr_ready = rdy;
        pcsrc       = pcs;
        jump        = jmp;
        pcbranch    = br;
        commit();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        instr_ready = 1'b0;
        pcsrc       = 1'b0;
        jump        = 1'b0;
        pcbranch    = 32'd0;
        imem_ack    = 1'b0;
        repeat (3) @(negedge clk);
        serving  = 1'b0;
        mem_lat  = 1;
        lat_rand = 1'b0;
        acks     = 0;
        ovr_n    = 0;
        ncons    = 0;
        exp_pc   = 32'h0000_0000;
        req_log.delete();
        cons_pcs.delete();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        int gaps;
        bit fired;
        bit found;
        logic r_rdy, r_pcs, r_jmp;
        int r;

        vecs[0] = '{32'h0800_0010, 1'b0, 1'b1, 32'h0000_0000, 1, 6'd2, 6'h10, 32'h0000_0040};
        vecs[1] = '{32'h0000_0020, 1'b0, 1'b0, 32'h0000_0000, 2, 6'd0, 6'h20, 32'h0000_0004};
        vecs[2] = '{32'h1000_0003, 1'b1, 1'b0, 32'h0000_0100, 1, 6'd4, 6'h03, 32'h0000_0100};
        vecs[3] = '{32'h0C00_0004, 1'b1, 1'b1, 32'h0000_0200, 3, 6'd3, 6'h04, 32'h0000_0010};
        vecs[4] = '{32'h0BFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 1, 6'd2, 6'h3F, 32'h0FFF_FFFC};
        vecs[5] = '{32'h1000_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFC, 2, 6'd4, 6'h3F, 32'hFFFF_FFFC};

        // reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_op", 32'(op), 32'd0);
        chk("rst_funct", 32'(funct), 32'd0);
        chk("rst_pcplus4", pcplus4, 32'd4);

        // streaming with 1-cycle memory, always ready
        do_reset();
        tick_a();
        chk("b_first_req", 32'(imem_req), 32'd1);
        chk("b_first_addr", imem_addr, 32'd0);
        tick_b(1'b1, 1'b0, 1'b0, 32'd0);
        gaps = 0;
        for (int i = 0; i < 20; i++) begin
            tick_a();
            if (!imem_req) gaps++;
            tick_b(1'b1, 1'b0, 1'b0, 32'd0);
        end
        chk("b_gaps", 32'(gaps), 32'd0);
        chk("b_nreq", 32'(req_log.size() >= 4), 32'd1);
        if (req_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("b_req_addr", req_log[i], 32'(4 * i));
        end
        chk("b_progress", 32'(ncons >= 5), 32'd1);

        // stall: FIFO fills with exactly DEPTH words, then resumes at 16
        do_reset();
        for (int i = 0; i < 30; i++) begin
            tick_a();
            tick_b(1'b0, 1'b0, 1'b0, 32'd0);
        end
        chk("c_acks", 32'(acks), 32'd4);
        chk("c_req_low", 32'(imem_req), 32'd0);
        chk("c_head_pc", pc, 32'd0);
        for (int i = 0; i < 20 && req_log.size() < 5; i++) begin
            tick_a();
            tick_b(1'b1, 1'b0, 1'b0, 32'd0);
        end
        chk("c_resume_seen", 32'(req_log.size() >= 5), 32'd1);
        if (req_log.size() >= 5) chk("c_resume_addr", req_log[4], 32'd16);

        // taken beq at pc 8 while the request to 12 is acked
        do_reset();
        fired = 1'b0;
        for (int i = 0; i < 60 && !fired; i++) begin
            tick_a();
            if (instr_valid && pc == 32'd8 && imem_ack && imem_addr == 32'd12) begin
                tick_b(1'b1, 1'b1, 1'b0, 32'h40);
                fired = 1'b1;
            end else if (instr_valid && pc != 32'd8) begin
                tick_b(1'b1, 1'b0, 1'b0, 32'd0);
            end else begin
                tick_b(1'b0, 1'b0, 1'b0, 32'd0);
            end
        end
        chk("d_fired", 32'(fired), 32'd1);
        n = cons_pcs.size();
        tick_a();
        chk("d_target_req", 32'(imem_req), 32'd1);
        chk("d_target_addr", imem_addr, 32'h40);
        tick_b(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (12) begin
            tick_a();
            tick_b(1'b1, 1'b0, 1'b0, 32'd0);
        end
        chk("d_next_seen", 32'(cons_pcs.size() > n), 32'd1);
        if (cons_pcs.size() > n) chk("d_next_pc", cons_pcs[n], 32'h40);

        // jump consumed while a slow request is outstanding -> drain
        do_reset();
        ovr_addr[0] = 32'h1000_0000;
        ovr_word[0] = 32'h0800_0010;
        ovr_n = 1;
        fired = 1'b0;
        for (int i = 0; i < 80 && !fired; i++) begin
            tick_a();
            if (instr_valid && pc == 32'h1000_0000 && imem_req && !imem_ack) begin
                tick_b(1'b1, 1'b0, 1'b1, 32'd0);
                fired = 1'b1;
            end else if (instr_valid && pc == 32'd0) begin
                tick_b(1'b1, 1'b1, 1'b0, 32'h1000_0000);
                mem_lat = 4;
            end else begin
                tick_b(1'b0, 1'b0, 1'b0, 32'd0);
            end
        end
        chk("e_fired", 32'(fired), 32'd1);
        n = req_log.size();
        tick_a();
        chk("e_drain_req", 32'(imem_req), 32'd1);
        chk("e_drain_addr", imem_addr, 32'h1000_0004);
        tick_b(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 20 && req_log.size() <= n; i++) begin
            tick_a();
            tick_b(1'b1, 1'b0, 1'b0, 32'd0);
        end
        chk("e_restart_seen", 32'(req_log.size() > n), 32'd1);
        if (req_log.size() > n) chk("e_restart_addr", req_log[n], 32'h1000_0040);
        n = cons_pcs.size();
        repeat (12) begin
            tick_a();
            tick_b(1'b1, 1'b0, 1'b0, 32'd0);
        end
        chk("e_next_seen", 32'(cons_pcs.size() > n), 32'd1);
        if (cons_pcs.size() > n) chk("e_next_pc", cons_pcs[n], 32'h1000_0040);

        // reset asserted mid-request
        do_reset();
        mem_lat = 6;
        repeat (2) begin
            tick_a();
            tick_b(1'b1, 1'b0, 1'b0, 32'd0);
        end
        chk("f_busy", 32'(imem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("f_async_req", 32'(imem_req), 32'd0);
        chk("f_async_addr", imem_addr, 32'd0);
        chk("f_async_valid", 32'(instr_valid), 32'd0);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            tick_a();
            tick_b(1'b1, 1'b0, 1'b0, 32'd0);
        end
        chk("f_restart_seen", 32'(req_log.size() > 0 && cons_pcs.size() > 0), 32'd1);
        if (req_log.size() > 0) chk("f_restart_addr", req_log[0], 32'd0);
        if (cons_pcs.size() > 0) chk("f_first_pc", cons_pcs[0], 32'd0);

        // fetch PC wraps from FFFF_FFFC to 0
        do_reset();
        for (int i = 0; i < 30; i++) begin
            tick_a();
            if (instr_valid && pc == 32'd0 && ncons == 0) tick_b(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC);
            else tick_b(1'b1, 1'b0, 1'b0, 32'd0);
        end
        found = 1'b0;
        for (int i = 0; i + 1 < req_log.size(); i++) begin
            if (!found && req_log[i] == 32'hFFFF_FFFC) begin
                found = 1'b1;
                chk("g_wrap_addr", req_log[i + 1], 32'd0);
            end
        end
        chk("g_wrap_found", 32'(found), 32'd1);

        // table-driven single-instruction redirect cases
        foreach (vecs[v]) begin
            do_reset();
            mem_lat     = vecs[v].lat;
            ovr_addr[0] = 32'd0;
            ovr_word[0] = vecs[v].word;
            ovr_n       = 1;
            fired = 1'b0;
            for (int i = 0; i < 20 && !fired; i++) begin
                tick_a();
                if (instr_valid) fired = 1'b1;
                else tick_b(1'b0, 1'b0, 1'b0, 32'd0);
            end
            chk("t_valid", 32'(fired), 32'd1);
            chk("t_op", 32'(op), 32'(vecs[v].exp_op));
            chk("t_funct", 32'(funct), 32'(vecs[v].exp_funct));
            chk("t_pcplus4", pcplus4, 32'd4);
            tick_b(1'b1, vecs[v].pcsrc, vecs[v].jump, vecs[v].br);
            n = cons_pcs.size();
            for (int i = 0; i < 40 && cons_pcs.size() <= n; i++) begin
                tick_a();
                tick_b(1'b1, 1'b0, 1'b0, 32'd0);
            end
            chk("t_next_seen", 32'(cons_pcs.size() > n), 32'd1);
            if (cons_pcs.size() > n) chk("t_next_pc", cons_pcs[n], vecs[v].exp_next);
        end

        // randomized traffic against the program-order model
        do_reset();
        lat_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick_a();
            r_rdy = ($urandom_range(0, 9) < 7);
            r     = int'($urandom_range(0, 19));
            r_pcs = (r == 0) || (r == 2);
            r_jmp = (r == 1) || (r == 2);
            tick_b(r_rdy, r_pcs, r_jmp, $urandom() & 32'hFFFF_FFFC);
        end
        chk("r_progress", 32'(ncons >= 300), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
